// File: rtl/sprite_blitter_pkg.sv
// Shared types and defaults for the sprite_blitter compositor.
// Optional transparency is selected in the top file by SPRITE_BLITTER_TRANSPARENCY_EN.
package sprite_blitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DEF_COLOR_W           = 3;
  localparam int DEF_TRANSPARENT_COLOR = 0;
  localparam int DEF_SCREEN_X          = 320;
  localparam int DEF_SCREEN_Y          = 240;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_blitter_scanner.sv
// Raster address counter over one SPR_W x SPR_H sprite: column fastest, row slowest.
// Flags the final pixel so the controller can move to the next channel.
module sprite_scanner
  import sprite_blitter_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      en,
  input  logic                      clear,
  output logic [idx_w(SPR_W)-1:0]   rom_x,
  output logic [idx_w(SPR_H)-1:0]   rom_y,
  output logic                      last
);

  localparam int XW = idx_w(SPR_W);
  localparam int YW = idx_w(SPR_H);
  localparam logic [XW-1:0] LAST_X = XW'(SPR_W - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(SPR_H - 1);

  logic end_of_row;

  assign end_of_row = (rom_x == LAST_X);
  assign last       = end_of_row && (rom_y == LAST_Y);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rom_x <= '0;
      rom_y <= '0;
    end else if (clear) begin
      rom_x <= '0;
      rom_y <= '0;
    end else if (en) begin
      if (end_of_row) begin
        rom_x <= '0;
        rom_y <= (rom_y == LAST_Y) ? '0 : rom_y + 1'b1;
      end else begin
        rom_x <= rom_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Multi-channel sprite compositor: walks channels 0..NUM_SPRITES-1 and streams plot/x/y/color.
// Define SPRITE_BLITTER_TRANSPARENCY_EN to suppress pixels whose colour equals TRANSPARENT_COLOR.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int NUM_SPRITES       = 4,
  parameter int SPR_W             = 16,
  parameter int SPR_H             = 16,
  parameter int WIDTH_X           = 9,
  parameter int WIDTH_Y           = 9,
  parameter int SCREEN_X          = DEF_SCREEN_X,
  parameter int SCREEN_Y          = DEF_SCREEN_Y,
  parameter int COLOR_W           = DEF_COLOR_W,
  parameter int TRANSPARENT_COLOR = DEF_TRANSPARENT_COLOR
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  input  logic [NUM_SPRITES-1:0]            layer_en,
  input  logic [NUM_SPRITES*WIDTH_X-1:0]    pos_x,
  input  logic [NUM_SPRITES*WIDTH_Y-1:0]    pos_y,
  output logic                              busy,
  output logic                              done,
  output logic [idx_w(NUM_SPRITES)-1:0]     rom_sel,
  output logic [idx_w(SPR_W)-1:0]           rom_x,
  output logic [idx_w(SPR_H)-1:0]           rom_y,
  input  logic [COLOR_W-1:0]                rom_color,
  output logic                              plot,
  output logic [WIDTH_X-1:0]                x,
  output logic [WIDTH_Y-1:0]                y,
  output logic [COLOR_W-1:0]                color,
  output logic [2:0]                        dbg_state
);

  localparam int SEL_W = idx_w(NUM_SPRITES);
  localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(NUM_SPRITES - 1);
  localparam logic [WIDTH_X:0]   LIM_X    = (WIDTH_X + 1)'(SCREEN_X);
  localparam logic [WIDTH_Y:0]   LIM_Y    = (WIDTH_Y + 1)'(SCREEN_Y);

  // Handshake: start is sampled only in IDLE (ignored, not queued, otherwise);
  // busy is high from the cycle after acceptance through DONE; done pulses once in DONE.
  state_t                 state;
  logic [SEL_W-1:0]       idx;
  logic [NUM_SPRITES-1:0] en_q;
  logic [WIDTH_X-1:0]     px_q [NUM_SPRITES];
  logic [WIDTH_Y-1:0]     py_q [NUM_SPRITES];

  logic                   scan_act;
  logic                   scan_last;
  logic                   last_chan;
  logic [WIDTH_X:0]       sx;
  logic [WIDTH_Y:0]       sy;
  logic                   plot_q;

  assign scan_act  = (state == ST_SCAN);
  assign last_chan = (idx == LAST_IDX);
  assign dbg_state = state;
  assign rom_sel   = scan_act ? idx : '0;

  sprite_scanner #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_scanner (
    .clk    (clk),
    .resetn (resetn),
    .en     (scan_act),
    .clear  (!scan_act),
    .rom_x  (rom_x),
    .rom_y  (rom_y),
    .last   (scan_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      idx   <= '0;
      en_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            en_q  <= layer_en;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_SELECT;
            for (int i = 0; i < NUM_SPRITES; i++) begin
              px_q[i] <= pos_x[i*WIDTH_X +: WIDTH_X];
              py_q[i] <= pos_y[i*WIDTH_Y +: WIDTH_Y];
            end
          end
        end
        ST_SELECT: begin
          if (en_q[idx]) begin
            state <= ST_SCAN;
          end else if (last_chan) begin
            state <= ST_DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_last) begin
            if (last_chan) begin
              state <= ST_DRAIN;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SELECT;
            end
          end
        end
        ST_DRAIN: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Extra top bit catches positions that run past the screen edge instead of wrapping.
  assign sx = {1'b0, px_q[idx]} + (WIDTH_X + 1)'(rom_x);
  assign sy = {1'b0, py_q[idx]} + (WIDTH_Y + 1)'(rom_y);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else begin
      plot_q <= scan_act && (sx < LIM_X) && (sy < LIM_Y);
      if (scan_act) begin
        x <= sx[WIDTH_X-1:0];
        y <= sy[WIDTH_Y-1:0];
      end
    end
  end

  // ROM data arrives in the same cycle as the registered coordinates, so colour is gated through.
  assign color = plot_q ? rom_color : '0;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam logic [COLOR_W-1:0] KEY = COLOR_W'(TRANSPARENT_COLOR);
  assign plot = plot_q && (rom_color != KEY);
`else
  logic unused_key;
  assign unused_key = ^(COLOR_W'(TRANSPARENT_COLOR));
  assign plot = plot_q;
`endif

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised scoreboard bench for sprite_blitter with 2 channels of 4x4 sprites on 320x240.
module tb_sprite_blitter;

  localparam int NS = 2;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int NPIX = SW * SH;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  layer_en = '0;
  logic [17:0] pos_x = '0;
  logic [17:0] pos_y = '0;
  logic        busy, done, plot;
  logic [0:0]  rom_sel;
  logic [1:0]  rom_x, rom_y;
  logic [2:0]  rom_color = '0;
  logic [8:0]  x, y;
  logic [2:0]  color;
  logic [2:0]  dbg_state;

  logic [2:0]  rom_mem [NS][NPIX];
  logic [20:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  sprite_blitter #(
    .NUM_SPRITES (NS),
    .SPR_W       (SW),
    .SPR_H       (SH),
    .WIDTH_X     (9),
    .WIDTH_Y     (9),
    .SCREEN_X    (320),
    .SCREEN_Y    (240),
    .COLOR_W     (3),
    .TRANSPARENT_COLOR (0)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .layer_en  (layer_en),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .busy      (busy),
    .done      (done),
    .rom_sel   (rom_sel),
    .rom_x     (rom_x),
    .rom_y     (rom_y),
    .rom_color (rom_color),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .color     (color),
    .dbg_state (dbg_state)
  );

  // Clock and synchronous sprite ROM (data one cycle after address).
  always #5 clk = ~clk;

  always @(posedge clk) rom_color <= rom_mem[rom_sel][{rom_y, rom_x}];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every plot strobe is popped against the scoreboard in order.
  always @(negedge clk) begin
    if (resetn && plot) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d color=%0d expected no plot", x, y, color);
      end else begin
        check("pixel", {11'd0, x, y, color}, {11'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic fill_const(input int ch, input logic [2:0] c);
    for (int i = 0; i < NPIX; i++) rom_mem[ch][i] = c;
  endtask

  task automatic fill_rand(input int ch);
    for (int i = 0; i < NPIX; i++) rom_mem[ch][i] = 3'($urandom_range(0, 7));
  endtask

  // Reference model: paint channels low to high, clip to screen, optionally drop the colour key.
  task automatic build_expected(input logic [1:0] en, input int px0, input int py0,
                                input int px1, input int py1);
    int px[NS];
    int py[NS];
    px[0] = px0; py[0] = py0; px[1] = px1; py[1] = py1;
    for (int ch = 0; ch < NS; ch++) begin
      if (en[ch]) begin
        for (int ry = 0; ry < SH; ry++) begin
          for (int rx = 0; rx < SW; rx++) begin
            int sx, sy;
            logic [2:0] c;
            bit vis;
            sx = px[ch] + rx;
            sy = py[ch] + ry;
            c = rom_mem[ch][ry * SW + rx];
            vis = (sx < 320) && (sy < 240);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
            if (c == 3'd0) vis = 1'b0;
`endif
            if (vis) exp_q.push_back({9'(sx), 9'(sy), c});
          end
        end
      end
    end
  endtask

  task automatic launch(input logic [1:0] en, input int px0, input int py0,
                        input int px1, input int py1);
    layer_en = en;
    pos_x = {9'(px1), 9'(px0)};
    pos_y = {9'(py1), 9'(py0)};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    layer_en = ~en;
    pos_x = 18'($urandom);
    pos_y = 18'($urandom);
  endtask

  task automatic run_pass(input logic [1:0] en, input int px0, input int py0,
                          input int px1, input int py1, input bit poke);
    int k, exp_done, cyc;
    bit got;
    k = int'(en[0]) + int'(en[1]);
    exp_done = NS + k * NPIX + 2;
    build_expected(en, px0, py0, px1, py1);
    launch(en, px0, py0, px1, py1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_cycle1", busy, 1);
      if (poke && cyc == 10) start = 1'b1;
      if (poke && cyc == 11) start = 1'b0;
      if (done) begin
        got = 1'b1;
        check("done_cycle", cyc, exp_done);
        check("busy_at_done", busy, 1);
      end
    end
    check("done_seen", got, 1);
    repeat (3) @(negedge clk);
    check("idle_after_pass", busy, 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_color"}, color, 0);
    check({tag, "_rom_addr"}, {rom_sel, rom_y, rom_x}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int cyc;
    for (int ch = 0; ch < NS; ch++) fill_const(ch, 3'd0);

    // Scenario 1: reset, then an empty pass.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    run_pass(2'b00, 0, 0, 0, 0, 1'b0);

    // Scenario 2: single channel, constant colour.
    fill_const(0, 3'b010);
    run_pass(2'b01, 10, 20, 0, 0, 1'b0);

    // Scenario 3: one keyed pixel at sprite (1,1).
    rom_mem[0][1 * SW + 1] = 3'b000;
    run_pass(2'b01, 10, 20, 0, 0, 1'b0);

    // Scenario 4: clipping at the bottom-right corner.
    fill_const(0, 3'b101);
    run_pass(2'b01, 318, 238, 0, 0, 1'b0);

    // Scenario 5: overlapping channels, ignored start mid-pass.
    fill_const(0, 3'b001);
    fill_const(1, 3'b100);
    run_pass(2'b11, 0, 0, 0, 0, 1'b1);

    // Scenario 6: reset in the fifth SCAN cycle, then a clean pass.
    fill_rand(0);
    build_expected(2'b01, 50, 60, 0, 0);
    launch(2'b01, 50, 60, 0, 0);
    cyc = 0;
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    resetn = 1'b0;
    #1;
    check("reset_mid_plot", plot, 0);
    check("reset_mid_busy", busy, 0);
    check("reset_mid_done", done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_all_zero("reset_mid_hold");
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_done", done, 0);
    run_pass(2'b01, 50, 60, 0, 0, 1'b0);

    // Randomised passes, positions biased to cover both clip edges.
    for (int t = 0; t < 12; t++) begin
      fill_rand(0);
      fill_rand(1);
      run_pass(2'($urandom_range(0, 3)),
               $urandom_range(0, 325), $urandom_range(0, 245),
               $urandom_range(0, 325), $urandom_range(0, 245),
               1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
